// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared types, sizes and helpers for the falling-note scroller
package note_pkg;

  localparam int NUM_LANES      = 4;
  localparam int SLOTS_PER_LANE = 4;

  typedef logic signed [12:0] coord_t;

  typedef struct packed {
    logic   active;
    coord_t y;
  } slot_t;

  // Saturating add of a small per-cycle event count onto a 16-bit total.
  function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [4:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {12'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/note_lane.sv
// rtl/note_lane.sv - one lane of four note slots: spawn, scroll, hit select, miss detect
// Ports:
//   clk, reset        clock, async active-high reset
//   tick              frame-advance strobe
//   spawn             accepted spawn for this lane (already qualified by free)
//   hit               button pulse for this lane
//   slots             current slot registers (active, top row y)
//   free              at least one slot inactive before this cycle
//   hit_cnt           1 when a hit retired a slot this cycle
//   miss_cnt          number of slots retired by a miss this cycle
module note_lane
  import note_pkg::*;
#(
  parameter int NOTE_H = 40,
  parameter int SPEED  = 4,
  parameter int HIT_Y  = 450,
  parameter int WINDOW = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       spawn,
  input  logic       hit,
  output slot_t      slots [SLOTS_PER_LANE],
  output logic       free,
  output logic       hit_cnt,
  output logic [2:0] miss_cnt
);

  slot_t      slot_q [SLOTS_PER_LANE];
  slot_t      slot_d [SLOTS_PER_LANE];
  logic [1:0] free_idx;
  logic [1:0] hit_idx;
  logic       hit_any;
  logic       hit_fire;

  // Lowest-index selection: scan downward so the last assignment wins.
  always_comb begin
    free     = 1'b0;
    free_idx = '0;
    hit_any  = 1'b0;
    hit_idx  = '0;
    for (int i = SLOTS_PER_LANE - 1; i >= 0; i--) begin
      if (!slot_q[i].active) begin
        free     = 1'b1;
        free_idx = 2'(i);
      end
      if (slot_q[i].active &&
          (int'(slot_q[i].y) + NOTE_H / 2 - HIT_Y) <= WINDOW &&
          (int'(slot_q[i].y) + NOTE_H / 2 - HIT_Y) >= -WINDOW) begin
        hit_any = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  assign hit_fire = hit && hit_any;

  // Spawn only targets a slot free before the cycle, so it never collides
  // with hit/tick handling of an active slot. A hit takes priority over tick.
  always_comb begin
    coord_t ny;
    ny       = '0;
    miss_cnt = '0;
    for (int i = 0; i < SLOTS_PER_LANE; i++) begin
      slot_d[i] = slot_q[i];
      if (spawn && free && free_idx == 2'(i)) begin
        slot_d[i] = '{active: 1'b1, y: coord_t'(-NOTE_H)};
      end else if (slot_q[i].active) begin
        if (hit_fire && hit_idx == 2'(i)) begin
          slot_d[i] = '0;
        end else if (tick) begin
          ny = slot_q[i].y + coord_t'(SPEED);
          if (int'(ny) + NOTE_H / 2 > HIT_Y + WINDOW) begin
            slot_d[i] = '0;
            miss_cnt  = miss_cnt + 3'd1;
          end else begin
            slot_d[i].y = ny;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLOTS_PER_LANE; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < SLOTS_PER_LANE; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign slots   = slot_q;
  assign hit_cnt = hit_fire;

endmodule

// File: rtl/note_scroller.sv
// rtl/note_scroller.sv - 4x4 falling-note geometry, hit/miss judging and bound outputs
// Ports:
//   clk, reset              clock, async active-high reset
//   tick                    one-cycle frame-advance strobe
//   spawn_valid/spawn_lane  spawn request and its lane
//   spawn_ready             requested lane has a free slot
//   hit[3:0]                button pulses, bit l = lane l
//   upBound/lowBound[16]    note top/bottom rows, index 4*lane+slot, 0 when inactive
//   leftBound/rightBound[4] constant lane horizontal extents
//   hit_pulse/miss_pulse    registered one-cycle event flags
//   hit_count/miss_count    saturating totals
module note_scroller
  import note_pkg::*;
#(
  parameter int NOTE_H  = 40,
  parameter int SPEED   = 4,
  parameter int HIT_Y   = 450,
  parameter int WINDOW  = 24,
  parameter int LANE_X0 = 160,
  parameter int LANE_W  = 80,
  parameter int NOTE_W  = 70
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               spawn_valid,
  input  logic [1:0]         spawn_lane,
  output logic               spawn_ready,
  input  logic [3:0]         hit,
  output logic signed [12:0] upBound    [16],
  output logic signed [12:0] lowBound   [16],
  output logic signed [12:0] leftBound  [4],
  output logic signed [12:0] rightBound [4],
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
);

  slot_t      lane_slots [NUM_LANES][SLOTS_PER_LANE];
  logic       lane_free  [NUM_LANES];
  logic       lane_hit   [NUM_LANES];
  logic [2:0] lane_miss  [NUM_LANES];
  logic [4:0] hit_sum;
  logic [4:0] miss_sum;

  assign spawn_ready = lane_free[spawn_lane];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    note_lane #(
      .NOTE_H (NOTE_H),
      .SPEED  (SPEED),
      .HIT_Y  (HIT_Y),
      .WINDOW (WINDOW)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .spawn    (spawn_valid && spawn_ready && spawn_lane == 2'(l)),
      .hit      (hit[l]),
      .slots    (lane_slots[l]),
      .free     (lane_free[l]),
      .hit_cnt  (lane_hit[l]),
      .miss_cnt (lane_miss[l])
    );
  end

  always_comb begin
    hit_sum  = '0;
    miss_sum = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      hit_sum  = hit_sum + {4'b0, lane_hit[l]};
      miss_sum = miss_sum + {2'b0, lane_miss[l]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      hit_count  <= sat_add16(hit_count, hit_sum);
      miss_count <= sat_add16(miss_count, miss_sum);
      hit_pulse  <= (hit_sum != '0);
      miss_pulse <= (miss_sum != '0);
    end
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      leftBound[l]  = coord_t'(LANE_X0 + l * LANE_W);
      rightBound[l] = coord_t'(LANE_X0 + l * LANE_W + NOTE_W);
      for (int s = 0; s < SLOTS_PER_LANE; s++) begin
        upBound[4*l+s]  = lane_slots[l][s].active ? lane_slots[l][s].y : '0;
        lowBound[4*l+s] = lane_slots[l][s].active ? lane_slots[l][s].y + coord_t'(NOTE_H) : '0;
      end
    end
  end

endmodule

// File: tb/tb_note_scroller.sv
// tb/tb_note_scroller.sv - self-checking bench for note_scroller
module tb_note_scroller;

  logic               clk = 1'b0;
  logic               reset;
  logic               tick;
  logic               spawn_valid;
  logic [1:0]         spawn_lane;
  logic               spawn_ready;
  logic [3:0]         hit;
  logic signed [12:0] upBound    [16];
  logic signed [12:0] lowBound   [16];
  logic signed [12:0] leftBound  [4];
  logic signed [12:0] rightBound [4];
  logic               hit_pulse;
  logic               miss_pulse;
  logic [15:0]        hit_count;
  logic [15:0]        miss_count;

  note_scroller dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .spawn_ready (spawn_ready),
    .hit         (hit),
    .upBound     (upBound),
    .lowBound    (lowBound),
    .leftBound   (leftBound),
    .rightBound  (rightBound),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  localparam int S_UP = 0, S_LOW = 1, S_LEFT = 2, S_RIGHT = 3, S_RDY = 4;
  localparam int S_HP = 5, S_MP = 6, S_HC = 7, S_MC = 8;

  typedef struct {
    string name;
    int    sel;
    int    idx;
    int    exp;
  } chk_t;

  typedef struct {
    logic       sv;
    logic [1:0] lane;
    logic       tk;
    string      name;
    int         sel;
    int         idx;
    int         exp;
  } vec_t;

  chk_t sb[$];
  vec_t fill_vecs[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  function automatic int dut_val(input int sel, input int idx);
    case (sel)
      S_UP:    return int'(upBound[idx]);
      S_LOW:   return int'(lowBound[idx]);
      S_LEFT:  return int'(leftBound[idx]);
      S_RIGHT: return int'(rightBound[idx]);
      S_RDY:   return int'(spawn_ready);
      S_HP:    return int'(hit_pulse);
      S_MP:    return int'(miss_pulse);
      S_HC:    return int'(hit_count);
      default: return int'(miss_count);
    endcase
  endfunction

  task automatic expect_v(input string n, input int sel, input int idx, input int e);
    sb.push_back('{name: n, sel: sel, idx: idx, exp: e});
  endtask

  task automatic check_all();
    chk_t c;
    int   got;
    while (sb.size() > 0) begin
      c   = sb.pop_front();
      got = dut_val(c.sel, c.idx);
      tests_run++;
      if (got != c.exp) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got %0d, expected %0d", c.name, c.idx, got, c.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick        = 1'b0;
    hit         = 4'b0;
    spawn_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step();
    end
  endtask

  task automatic spawn(input int l);
    spawn_valid = 1'b1;
    spawn_lane  = 2'(l);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // lane-0 fill sequence, held fifth request, then tick with a same-cycle spawn
    fill_vecs.push_back('{1'b1, 2'd0, 1'b0, "fill_up",       S_UP, 0, -40});
    fill_vecs.push_back('{1'b1, 2'd0, 1'b0, "fill_up",       S_UP, 1, -40});
    fill_vecs.push_back('{1'b1, 2'd0, 1'b0, "fill_up",       S_UP, 2, -40});
    fill_vecs.push_back('{1'b1, 2'd0, 1'b0, "fill_up",       S_UP, 3, -40});
    fill_vecs.push_back('{1'b1, 2'd0, 1'b0, "held_up",       S_UP, 4, 0});
    fill_vecs.push_back('{1'b0, 2'd0, 1'b0, "held_up",       S_UP, 0, -40});
    fill_vecs.push_back('{1'b0, 2'd0, 1'b0, "held_low",      S_LOW, 3, 0});
    fill_vecs.push_back('{1'b1, 2'd1, 1'b1, "tickspawn_up",  S_UP, 0, -36});
    fill_vecs.push_back('{1'b0, 2'd0, 1'b0, "tickspawn_up",  S_UP, 4, -40});
    fill_vecs.push_back('{1'b0, 2'd0, 1'b0, "tickspawn_low", S_LOW, 3, 4});

    reset       = 1'b1;
    tick        = 1'b0;
    hit         = 4'b0;
    spawn_valid = 1'b0;
    spawn_lane  = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state
    for (int i = 0; i < 16; i++) begin
      expect_v("rst_up", S_UP, i, 0);
      expect_v("rst_low", S_LOW, i, 0);
    end
    for (int l = 0; l < 4; l++) begin
      expect_v("rst_left", S_LEFT, l, 160 + 80 * l);
      expect_v("rst_right", S_RIGHT, l, 230 + 80 * l);
    end
    expect_v("rst_ready", S_RDY, 0, 1);
    expect_v("rst_hc", S_HC, 0, 0);
    expect_v("rst_mc", S_MC, 0, 0);
    expect_v("rst_hp", S_HP, 0, 0);
    expect_v("rst_mp", S_MP, 0, 0);
    check_all();

    // Spawn lane 2, then 10 ticks
    spawn(2);
    expect_v("sp2_up", S_UP, 8, -40);
    expect_v("sp2_low", S_LOW, 8, 0);
    check_all();
    ticks(10);
    expect_v("sp2t_up", S_UP, 8, 0);
    expect_v("sp2t_low", S_LOW, 8, 40);
    expect_v("sp2t_up", S_UP, 9, 0);
    expect_v("sp2t_low", S_LOW, 9, 0);
    expect_v("sp2t_up", S_UP, 0, 0);
    check_all();

    // Fill lane 0 (table-driven), with spawn_ready probes before the held request
    do_reset();
    for (int v = 0; v < fill_vecs.size(); v++) begin
      if (v == 4) begin
        spawn_lane = 2'd0;
        #1;
        expect_v("full_ready_l0", S_RDY, 0, 0);
        check_all();
        spawn_lane = 2'd1;
        #1;
        expect_v("full_ready_l1", S_RDY, 1, 1);
        check_all();
      end
      spawn_valid = fill_vecs[v].sv;
      spawn_lane  = fill_vecs[v].lane;
      tick        = fill_vecs[v].tk;
      step();
      expect_v(fill_vecs[v].name, fill_vecs[v].sel, fill_vecs[v].idx, fill_vecs[v].exp);
      check_all();
    end

    // Lane 1 hit at centre 448, hit arrives together with a tick
    do_reset();
    spawn(1);
    ticks(117);
    expect_v("l1_pre_up", S_UP, 4, 428);
    check_all();
    hit  = 4'b0010;
    tick = 1'b1;
    step();
    expect_v("l1_hit_hp", S_HP, 0, 1);
    expect_v("l1_hit_hc", S_HC, 0, 1);
    expect_v("l1_hit_up", S_UP, 4, 0);
    expect_v("l1_hit_low", S_LOW, 4, 0);
    expect_v("l1_hit_mc", S_MC, 0, 0);
    check_all();
    step();
    expect_v("l1_hp_drop", S_HP, 0, 0);
    expect_v("l1_hc_hold", S_HC, 0, 1);
    check_all();

    // Two lanes hit in the same cycle
    do_reset();
    spawn(0);
    spawn(1);
    ticks(117);
    hit = 4'b0011;
    step();
    expect_v("dual_hc", S_HC, 0, 2);
    expect_v("dual_hp", S_HP, 0, 1);
    expect_v("dual_up", S_UP, 0, 0);
    check_all();

    // Lane 3: early hit ignored, then missed on the 124th tick
    do_reset();
    spawn(3);
    ticks(100);
    hit = 4'b1000;
    step();
    expect_v("early_hp", S_HP, 0, 0);
    expect_v("early_hc", S_HC, 0, 0);
    expect_v("early_up", S_UP, 12, 360);
    check_all();
    ticks(23);
    expect_v("edge_up", S_UP, 12, 452);
    expect_v("edge_mc", S_MC, 0, 0);
    check_all();
    ticks(1);
    expect_v("miss_up", S_UP, 12, 0);
    expect_v("miss_mp", S_MP, 0, 1);
    expect_v("miss_mc", S_MC, 0, 1);
    check_all();
    step();
    expect_v("miss_mp_drop", S_MP, 0, 0);
    check_all();

    // Asynchronous reset mid-scroll
    spawn(0);
    ticks(5);
    expect_v("pre_rst_up", S_UP, 0, -20);
    expect_v("pre_rst_mc", S_MC, 0, 1);
    check_all();
    #2;
    reset = 1'b1;
    #1;
    expect_v("async_up", S_UP, 0, 0);
    expect_v("async_low", S_LOW, 0, 0);
    expect_v("async_mc", S_MC, 0, 0);
    expect_v("async_left", S_LEFT, 3, 400);
    check_all();
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
